// File: rtl/n64adv_igr_decoder_pkg.sv
// Shared definitions for the in-game-routine decoder: button masks, FSM states,
// combo indices and small helpers used by the decoder and its per-combo FSMs.
package n64adv_igr_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        HOLD  = 2'b01,
        FIRED = 2'b10
    } igr_state_e;

    localparam logic [15:0] MASK_RESET  = 16'h080F;
    localparam logic [15:0] MASK_OSD    = 16'h8C80;
    localparam logic [15:0] MASK_DEBLUR = 16'h880C;
    localparam logic [15:0] MASK_MODE16 = 16'h480C;

    localparam int IDX_RESET  = 0;
    localparam int IDX_OSD    = 1;
    localparam int IDX_DEBLUR = 2;
    localparam int IDX_MODE16 = 3;
    localparam int NUM_COMBOS = 4;

    function automatic logic [15:0] combo_mask(input int idx);
        case (idx)
            IDX_RESET:  combo_mask = MASK_RESET;
            IDX_OSD:    combo_mask = MASK_OSD;
            IDX_DEBLUR: combo_mask = MASK_DEBLUR;
            default:    combo_mask = MASK_MODE16;
        endcase
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] value);
        sat_inc4 = (value == 4'hF) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/n64adv_igr_decoder_combo.sv
// One IGR combo: IDLE/HOLD/FIRED FSM with a saturating hold counter and, when
// N64ADV_IGR_AUTOREPEAT_EN is defined, a repeat counter (REPEAT_POLLS = 0 disables repeat).
module n64adv_igr_decoder_combo
    import n64adv_igr_decoder_pkg::*;
#(
    parameter logic [15:0] MASK         = 16'h0000,
    parameter int unsigned HOLD_POLLS   = 4,
    parameter int unsigned REPEAT_POLLS = 0
) (
    input  logic        CLK_4M,
    input  logic        SRST_4M,
    input  logic        poll_valid,
    input  logic [15:0] buttons,
    input  logic        force_idle,
    output logic        fire,
    output logic        active
);

    igr_state_e state, state_next;
    logic [3:0] hold_cnt, hold_cnt_next;
    logic       match;

    assign match  = (buttons == MASK);
    assign active = (state != IDLE);

`ifdef N64ADV_IGR_AUTOREPEAT_EN
    logic [7:0] rep_cnt, rep_cnt_next;

    always_ff @(posedge CLK_4M) begin
        if (SRST_4M) rep_cnt <= 8'd0;
        else         rep_cnt <= rep_cnt_next;
    end
`else
    localparam int unsigned unused_repeat_polls = REPEAT_POLLS;
`endif

    always_ff @(posedge CLK_4M) begin
        if (SRST_4M) begin
            state    <= IDLE;
            hold_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    // Only polls advance the FSM; force_idle (stale link or IGR disabled) overrides everything.
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        fire          = 1'b0;
`ifdef N64ADV_IGR_AUTOREPEAT_EN
        rep_cnt_next  = rep_cnt;
`endif
        if (force_idle) begin
            state_next    = IDLE;
            hold_cnt_next = 4'd0;
`ifdef N64ADV_IGR_AUTOREPEAT_EN
            rep_cnt_next  = 8'd0;
`endif
        end else if (poll_valid) begin
            if (!match) begin
                state_next    = IDLE;
                hold_cnt_next = 4'd0;
`ifdef N64ADV_IGR_AUTOREPEAT_EN
                rep_cnt_next  = 8'd0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        hold_cnt_next = 4'd1;
`ifdef N64ADV_IGR_AUTOREPEAT_EN
                        rep_cnt_next  = 8'd0;
`endif
                        if (HOLD_POLLS == 1) begin
                            fire       = 1'b1;
                            state_next = FIRED;
                        end else begin
                            state_next = HOLD;
                        end
                    end
                    HOLD: begin
                        hold_cnt_next = sat_inc4(hold_cnt);
                        if ((5'(hold_cnt) + 5'd1) == 5'(HOLD_POLLS)) begin
                            fire       = 1'b1;
                            state_next = FIRED;
                        end
                    end
                    FIRED: begin
                        state_next = FIRED;
`ifdef N64ADV_IGR_AUTOREPEAT_EN
                        if (REPEAT_POLLS != 0) begin
                            if ((9'(rep_cnt) + 9'd1) == 9'(REPEAT_POLLS)) begin
                                fire         = 1'b1;
                                rep_cnt_next = 8'd0;
                            end else begin
                                rep_cnt_next = rep_cnt + 8'd1;
                            end
                        end
`endif
                    end
                    default: begin
                        state_next    = IDLE;
                        hold_cnt_next = 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/n64adv_igr_decoder.sv
// IGR decoder top: four combo FSMs, stale-poll timer, IGR_EN gating and registered pulses.
// Optional auto-repeat of toggle commands via macro N64ADV_IGR_AUTOREPEAT_EN.
module n64adv_igr_decoder
    import n64adv_igr_decoder_pkg::*;
#(
    parameter int unsigned HOLD_POLLS   = 4,
    parameter logic [17:0] STALE_CYCLES = 18'd200000,
    parameter int unsigned REPEAT_POLLS = 30
) (
    input  logic        CLK_4M,
    input  logic        SRST_4M,
    input  logic [31:0] CTRL_DATA,
    input  logic        CTRL_VALID,
    input  logic        IGR_EN,
    output logic        RESET_REQ,
    output logic        OSD_TOGGLE,
    output logic        DEBLUR_TOGGLE,
    output logic        MODE16_TOGGLE,
    output logic [3:0]  COMBO_HOLD
);

    logic [17:0] stale_cnt;
    logic        stale;
    logic        force_idle;
    logic [3:0]  fire;
    logic [3:0]  pulse_q;
    logic [15:0] unused_axes;

    assign unused_axes = CTRL_DATA[31:16];

    // A poll in the expiry cycle wins over the timeout.
    assign stale      = !CTRL_VALID && (stale_cnt == STALE_CYCLES);
    assign force_idle = stale || !IGR_EN;

    always_ff @(posedge CLK_4M) begin
        if (SRST_4M)                      stale_cnt <= 18'd0;
        else if (CTRL_VALID)              stale_cnt <= 18'd0;
        else if (stale_cnt != STALE_CYCLES) stale_cnt <= stale_cnt + 18'd1;
    end

    for (genvar k = 0; k < NUM_COMBOS; k++) begin : g_combo
        n64adv_igr_decoder_combo #(
            .MASK         (combo_mask(k)),
            .HOLD_POLLS   (HOLD_POLLS),
            .REPEAT_POLLS ((k == IDX_RESET) ? 0 : REPEAT_POLLS)
        ) u_combo (
            .CLK_4M     (CLK_4M),
            .SRST_4M    (SRST_4M),
            .poll_valid (CTRL_VALID),
            .buttons    (CTRL_DATA[15:0]),
            .force_idle (force_idle),
            .fire       (fire[k]),
            .active     (COMBO_HOLD[k])
        );
    end

    always_ff @(posedge CLK_4M) begin
        if (SRST_4M) pulse_q <= 4'b0000;
        else         pulse_q <= fire & {4{IGR_EN}};
    end

    // Dropping IGR_EN also kills a pulse that is already registered.
    assign RESET_REQ     = pulse_q[IDX_RESET]  & IGR_EN;
    assign OSD_TOGGLE    = pulse_q[IDX_OSD]    & IGR_EN;
    assign DEBLUR_TOGGLE = pulse_q[IDX_DEBLUR] & IGR_EN;
    assign MODE16_TOGGLE = pulse_q[IDX_MODE16] & IGR_EN;

endmodule

// File: tb/tb_n64adv_igr_decoder.sv
// Self-checking bench for n64adv_igr_decoder: expected pulses are queued when polls are
// driven and matched against observed pulses; stale timeout is shortened for run time.
module tb_n64adv_igr_decoder;

    localparam int          HOLD   = 4;
    localparam logic [17:0] STALE  = 18'd200;
    localparam int          REPEAT = 30;
    localparam int          GAP    = 20;

    logic        clk = 1'b0;
    logic        srst;
    logic [31:0] ctrl_data;
    logic        ctrl_valid;
    logic        igr_en;
    logic        reset_req, osd_toggle, deblur_toggle, mode16_toggle;
    logic [3:0]  combo_hold;

    typedef struct {
        int       cyc;
        logic [3:0] pulses;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [3:0] seen;
    exp_t e;

    n64adv_igr_decoder #(
        .HOLD_POLLS   (HOLD),
        .STALE_CYCLES (STALE),
        .REPEAT_POLLS (REPEAT)
    ) dut (
        .CLK_4M        (clk),
        .SRST_4M       (srst),
        .CTRL_DATA     (ctrl_data),
        .CTRL_VALID    (ctrl_valid),
        .IGR_EN        (igr_en),
        .RESET_REQ     (reset_req),
        .OSD_TOGGLE    (osd_toggle),
        .DEBLUR_TOGGLE (deblur_toggle),
        .MODE16_TOGGLE (mode16_toggle),
        .COMBO_HOLD    (combo_hold)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every observed pulse must match the head of the queue in cycle and bits.
    always @(negedge clk) begin
        seen = {mode16_toggle, deblur_toggle, osd_toggle, reset_req};
        while (sb.size() != 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("[TB] FAIL missing_pulse: got none at cycle %0d, required %b", e.cyc, e.pulses);
        end
        if (seen !== 4'b0000) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL unexpected_pulse: got %b at cycle %0d, required none", seen, cyc);
            end else begin
                e = sb.pop_front();
                if (e.pulses !== seen || e.cyc != cyc) begin
                    n_fail++;
                    $display("[TB] FAIL pulse: got %b at cycle %0d, required %b at cycle %0d",
                             seen, cyc, e.pulses, e.cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic poll(input logic [15:0] btn, input logic [3:0] expect_pulse);
        logic [31:0] d;
        d = $urandom;
        d[15:0] = btn;
        if (expect_pulse != 4'b0000) sb.push_back('{cyc + 1, expect_pulse});
        ctrl_data  = d;
        ctrl_valid = 1'b1;
        tick(1);
        ctrl_valid = 1'b0;
    endtask

    task automatic poll_gap(input logic [15:0] btn, input logic [3:0] expect_pulse);
        poll(btn, expect_pulse);
        tick(GAP);
    endtask

    task automatic drain(input string name);
        tick(3);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL %s_drain: got %0d pending pulses, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic release_all();
        poll_gap(16'h0000, 4'b0000);
    endtask

    task automatic test_reset();
        srst = 1'b1; igr_en = 1'b1; ctrl_valid = 1'b0; ctrl_data = 32'h0;
        tick(3);
        n_checks++;
        if ({reset_req, osd_toggle, deblur_toggle, mode16_toggle, combo_hold} !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %b, required 00000000",
                     {reset_req, osd_toggle, deblur_toggle, mode16_toggle, combo_hold});
        end
        srst = 1'b0;
        tick(2);
    endtask

    task automatic test_reset_combo();
        poll(16'h080F, 4'b0000);
        n_checks++;
        if (combo_hold !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL reset_combo_hold_first: got %b, required 0001", combo_hold);
        end
        tick(GAP);
        poll_gap(16'h080F, 4'b0000);
        poll_gap(16'h080F, 4'b0000);
        poll(16'h080F, 4'b0001);
        n_checks++;
        if (combo_hold !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL reset_combo_hold_fired: got %b, required 0001", combo_hold);
        end
        tick(GAP);
        poll_gap(16'h080F, 4'b0000);
        release_all();
        n_checks++;
        if (combo_hold !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_combo_release: got %b, required 0000", combo_hold);
        end
        drain("reset_combo");
    endtask

    task automatic test_osd_interrupted();
        for (int i = 0; i < 3; i++) poll_gap(16'h8C80, 4'b0000);
        poll(16'h8C81, 4'b0000);
        n_checks++;
        if (combo_hold !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL osd_break_hold: got %b, required 0000", combo_hold);
        end
        tick(GAP);
        for (int i = 0; i < 4; i++) poll_gap(16'h8C80, (i == 3) ? 4'b0010 : 4'b0000);
        release_all();
        drain("osd");
    endtask

    task automatic test_deblur_hold();
        for (int i = 1; i <= 40; i++) begin
`ifdef N64ADV_IGR_AUTOREPEAT_EN
            poll(16'h880C, (i == 4 || i == 34) ? 4'b0100 : 4'b0000);
`else
            poll(16'h880C, (i == 4) ? 4'b0100 : 4'b0000);
`endif
            tick(3);
        end
        n_checks++;
        if (combo_hold !== 4'b0100) begin
            n_fail++;
            $display("[TB] FAIL deblur_hold_status: got %b, required 0100", combo_hold);
        end
        release_all();
        drain("deblur");
    endtask

    task automatic test_stale_timeout();
        poll_gap(16'h480C, 4'b0000);
        poll_gap(16'h480C, 4'b0000);
        poll(16'h480C, 4'b0000);
        tick(STALE);
        n_checks++;
        if (combo_hold !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL stale_before_expiry: got %b, required 1000", combo_hold);
        end
        tick(1);
        n_checks++;
        if (combo_hold !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL stale_at_expiry: got %b, required 0000", combo_hold);
        end
        tick(GAP);
        poll(16'h480C, 4'b0000);
        n_checks++;
        if (combo_hold !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL stale_restart: got %b, required 1000", combo_hold);
        end
        tick(GAP);
        poll_gap(16'h480C, 4'b0000);
        poll_gap(16'h480C, 4'b0000);
        poll_gap(16'h480C, 4'b1000);
        release_all();
        drain("stale");
    endtask

    task automatic test_igr_en_drop();
        for (int i = 0; i < 3; i++) poll_gap(16'h080F, 4'b0000);
        igr_en = 1'b0;
        poll(16'h080F, 4'b0000);
        n_checks++;
        if (combo_hold !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL igr_en_low_hold: got %b, required 0000", combo_hold);
        end
        tick(GAP);
        igr_en = 1'b1;
        tick(2);
        for (int i = 0; i < 3; i++) poll_gap(16'h080F, 4'b0000);
        poll(16'h080F, 4'b0000);
        igr_en = 1'b0;
        tick(GAP);
        igr_en = 1'b1;
        tick(2);
        release_all();
        for (int i = 0; i < 4; i++) poll_gap(16'h080F, (i == 3) ? 4'b0001 : 4'b0000);
        release_all();
        drain("igr_en");
    endtask

    task automatic test_srst_mid_hold();
        poll_gap(16'h080F, 4'b0000);
        poll_gap(16'h080F, 4'b0000);
        srst = 1'b1;
        tick(2);
        n_checks++;
        if ({reset_req, osd_toggle, deblur_toggle, mode16_toggle, combo_hold} !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL srst_mid_hold: got %b, required 00000000",
                     {reset_req, osd_toggle, deblur_toggle, mode16_toggle, combo_hold});
        end
        srst = 1'b0;
        tick(2);
        for (int i = 0; i < 3; i++) poll_gap(16'h080F, 4'b0000);
        n_checks++;
        if (combo_hold !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL srst_recount: got %b, required 0001", combo_hold);
        end
        srst = 1'b1;
        poll(16'h080F, 4'b0000);
        srst = 1'b0;
        n_checks++;
        if (combo_hold !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL srst_coincident: got %b, required 0000", combo_hold);
        end
        tick(GAP);
        release_all();
        drain("srst");
    endtask

    task automatic test_stale_coincident();
        poll(16'h080F, 4'b0000);
        tick(STALE);
        poll(16'h080F, 4'b0000);
        n_checks++;
        if (combo_hold !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL coincident_hold: got %b, required 0001", combo_hold);
        end
        tick(GAP);
        poll_gap(16'h080F, 4'b0000);
        poll_gap(16'h080F, 4'b0001);
        release_all();
        drain("coincident");
    endtask

    initial begin
        test_reset();
        test_reset_combo();
        test_osd_interrupted();
        test_deblur_hold();
        test_stale_timeout();
        test_igr_en_drop();
        test_srst_mid_hold();
        test_stale_coincident();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
